test: RTL and testbench
=======================

// Module: test
//
// PURPOSE
//  Nine-digit decimal (BCD-style) up-counter with a preset value, for a
//  TinyTapeout-style top wrapper.
//  - Clock and reset arrive on the packed io_in bus.
//  - While reset is asserted, the counter is loaded from a 45-bit init word.
//  - After reset releases, it counts up by 1 each clock.
//  - Every digit is presented on its own 5-bit output.
//
// PARAMETERS
//  NUM_DIGITS  9  number of decimal digits (ones .. hundred-millions)
//  DIGIT_W     5  bits per digit field (on init and on each output)
//
// PORTS
//  io_in[0]  in   1   clk; single clock, rising-edge active
//  io_in[1]  in   1   rst_n; asynchronous, active-low reset/preset
//  io_in[7:2] in  6   unused, ignored
//  init      in   45  preset: [44:40]=hunM [39:35]=tenM [34:30]=mil [29:25]=hunT
//                     [24:20]=tenT [19:15]=thou [14:10]=hund [9:5]=tens [4:0]=ones
//  ones      out  5   10^0 digit
//  tens      out  5   10^1 digit
//  hund      out  5   10^2 digit
//  thou      out  5   10^3 digit
//  tenT      out  5   10^4 digit
//  hunT      out  5   10^5 digit
//  mil       out  5   10^6 digit
//  tenM      out  5   10^7 digit
//  hunM      out  5   10^8 digit
//
// BEHAVIOUR
//  - Reset: rst_n=0 asynchronously loads every digit register from its init
//    slice, with no clock needed.
//    - While rst_n stays low, the digits track init (level-sensitive preset).
//    - The reset value of each output equals its init slice.
//  - Count: on each rising clk with rst_n=1, the 9-digit value increments by 1.
//    Outputs are the registers directly, so latency is 1 clock.
//  - Digit rule: legal digit value is 0..9, with bit 4 = 0.
//    - The ones digit increments every cycle.
//    - Digit k increments only when all lower digits carry.
//    - A digit carries when its value is >= 9; on carry it becomes 0.
//    - Otherwise the digit becomes value+1.
//  - Illegal preset values (10..31) are not clamped at load.
//    - They are reported as-is until that digit next increments.
//    - On that increment they become 0 and carry, i.e. they behave like 9.
//  - Wrap-around: 999_999_999 -> 000_000_000 on the next clock.
//    No carry-out or overflow flag.
//  - Carry is combinational through all 9 digits in one cycle.
//    It is not pipelined, so there is no ripple delay visible on the outputs.
//  - Reset during counting: the preset takes effect immediately.
//    Counting resumes from init on the first rising clk after rst_n goes high.
//  - io_in[7:2] has no effect under any condition.
//
// STRUCTURE
//  - Shared package: NUM_DIGITS=9, DIGIT_W=5, DIGIT_MAX=9, and a digit_t
//    typedef (logic [DIGIT_W-1:0]).
//  - Sub-module bcd_digit, instantiated 9x, with ports:
//    clk, rst_n, init_d, carry_in -> q, carry_out.
//    - It holds one async-preset register and the increment/wrap logic.
//    - carry_out = carry_in && (q >= 9).
//    - The ones digit gets carry_in = 1.
//  - The top level unpacks io_in and init and chains the carries.
//
// TESTING
//  - Preset: init = digits 1,2,3,4,5,6,7,8,9 (hunM..ones), rst_n=0
//    -> outputs 1..9 immediately, with no clock edge.
//  - Count: init = 0, release rst_n, 12 clocks -> tens=1, ones=2,
//    all other digits 0.
//  - Ripple: init = 000_000_999, 1 clock -> thou=1, hund=0, tens=0, ones=0.
//  - Wrap: init = 999_999_999, 1 clock -> all nine digits 0.
//    A second clock gives ones=1.
//  - Async reset mid-count: init = 000_000_500, count 7 clocks (507).
//    Assert rst_n between edges -> 500 immediately.
//    Then release and clock 1 -> 501.
//  - Illegal preset: ones init = 15, 1 clock -> ones=0, tens incremented by 1.
//    Toggling io_in[7:2] changes nothing.

Source files
------------

// File: rtl/test_pkg.sv
// ============================================================================
// test_pkg : shared constants and types for the nine-digit decimal counter.
// Rev 1.0
// ============================================================================
`default_nettype none

package test_pkg;

    localparam int NUM_DIGITS = 9;
    localparam int DIGIT_W    = 5;
    localparam int INIT_W     = NUM_DIGITS * DIGIT_W;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_MAX = digit_t'(9);

endpackage

`default_nettype wire

// File: rtl/test_if.sv
// ============================================================================
// test_if : TinyTapeout-style pin bundle (io_in, preset word, nine digit outputs).
// Rev 1.0
// ============================================================================
`default_nettype none

interface test_if;

    logic [7:0]                  io_in;
    logic [test_pkg::INIT_W-1:0] init;

    test_pkg::digit_t ones;
    test_pkg::digit_t tens;
    test_pkg::digit_t hund;
    test_pkg::digit_t thou;
    test_pkg::digit_t tenT;
    test_pkg::digit_t hunT;
    test_pkg::digit_t mil;
    test_pkg::digit_t tenM;
    test_pkg::digit_t hunM;

    modport master (
        output io_in, init,
        input  ones, tens, hund, thou, tenT, hunT, mil, tenM, hunM
    );

    modport slave (
        input  io_in, init,
        output ones, tens, hund, thou, tenT, hunT, mil, tenM, hunM
    );

endinterface

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// bcd_digit : one decimal digit with async preset and increment/wrap logic.
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit
    import test_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  digit_t    init_d,
    input  wire logic carry_in,
    output digit_t    q,
    output logic      carry_out
);

    digit_t q_q;
    digit_t q_d;

    // Values 10..31 can only come from the preset; treating them like 9 means
    // they wrap to 0 and carry on their first increment.
    always_comb begin
        q_d       = q_q;
        carry_out = carry_in && (q_q >= DIGIT_MAX);
        if (carry_in) begin
            q_d = (q_q >= DIGIT_MAX) ? '0 : q_q + digit_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= init_d;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/test.sv
// ============================================================================
// test : nine-digit decimal up-counter with preset, clock/reset on io_in.
// Rev 1.0
// ============================================================================
`default_nettype none

module test
    import test_pkg::*;
(
    test_if.slave bus
);

    logic                clk;
    logic                rst_n;
    logic [NUM_DIGITS:0] carry_w;
    digit_t              digit_q [NUM_DIGITS];
    logic [6:0]          unused_w;

    assign clk   = bus.io_in[0];
    assign rst_n = bus.io_in[1];

    // Top carry-out is dropped: the counter wraps silently with no overflow flag.
    assign unused_w   = {bus.io_in[7:2], carry_w[NUM_DIGITS]};
    assign carry_w[0] = 1'b1;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .init_d    (bus.init[k*DIGIT_W +: DIGIT_W]),
            .carry_in  (carry_w[k]),
            .q         (digit_q[k]),
            .carry_out (carry_w[k+1])
        );
    end

    assign bus.ones = digit_q[0];
    assign bus.tens = digit_q[1];
    assign bus.hund = digit_q[2];
    assign bus.thou = digit_q[3];
    assign bus.tenT = digit_q[4];
    assign bus.hunT = digit_q[5];
    assign bus.mil  = digit_q[6];
    assign bus.tenM = digit_q[7];
    assign bus.hunM = digit_q[8];

endmodule

`default_nettype wire

// File: tb/tb_test.sv
// ============================================================================
// tb_test : directed self-checking bench for the nine-digit decimal counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_test;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  junk  = 6'd0;
    logic [44:0] got;
    int          n_cmp = 0;
    int          n_bad = 0;

    test_if bus ();

    assign bus.io_in = {junk, rst_n, clk};

    test u_dut (
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign got = {bus.hunM, bus.tenM, bus.mil, bus.hunT, bus.tenT,
                  bus.thou, bus.hund, bus.tens, bus.ones};

    // Expands a 9-nibble BCD literal into the 45-bit 5-bit-per-digit layout.
    function automatic logic [44:0] pk(input logic [35:0] bcd);
        logic [44:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r[i*5 +: 5] = {1'b0, bcd[i*4 +: 4]};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [44:0] obs, input logic [44:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Loads a preset between clock edges via a fresh falling edge on rst_n.
    task automatic preset(input logic [44:0] v);
        @(negedge clk);
        bus.init = v;
        rst_n    = 1'b1;
        #1;
        rst_n    = 1'b0;
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.init = '0;

        // Preset with no clock edge at all (first posedge is at t=5)
        #1;
        bus.init = pk(36'h1_2345_6789);
        #1;
        rst_n = 1'b0;
        #1;
        chk("preset_word", got, pk(36'h1_2345_6789));
        chk("preset_ones", {40'd0, bus.ones}, 45'd9);
        chk("preset_hunM", {40'd0, bus.hunM}, 45'd1);

        // Held in reset across clocks: no counting
        ticks(3);
        chk("hold_in_reset", got, pk(36'h1_2345_6789));

        // Count from zero
        preset(45'd0);
        chk("count_preset", got, 45'd0);
        release_rst();
        ticks(12);
        chk("count_12", got, pk(36'h0_0000_0012));

        // Ripple through three digits in one clock
        preset(pk(36'h0_0000_0999));
        chk("ripple_preset", got, pk(36'h0_0000_0999));
        release_rst();
        ticks(1);
        chk("ripple_1000", got, pk(36'h0_0000_1000));

        // Full wrap-around
        preset(pk(36'h9_9999_9999));
        release_rst();
        ticks(1);
        chk("wrap_zero", got, 45'd0);
        ticks(1);
        chk("wrap_one", got, pk(36'h0_0000_0001));

        // Async reset mid-count, asserted between edges
        preset(pk(36'h0_0000_0500));
        release_rst();
        ticks(7);
        chk("mid_507", got, pk(36'h0_0000_0507));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_500", got, pk(36'h0_0000_0500));
        @(negedge clk);
        rst_n = 1'b1;
        ticks(1);
        chk("mid_501", got, pk(36'h0_0000_0501));

        // Illegal ones preset (15) reported as-is, then behaves like 9
        preset({35'd0, 5'd3, 5'd15});
        chk("illegal_preset", got, {35'd0, 5'd3, 5'd15});
        release_rst();
        ticks(1);
        chk("illegal_wrap", got, pk(36'h0_0000_0040));

        // io_in[7:2] toggling has no effect
        junk = 6'h3F;
        ticks(1);
        chk("junk_3f", got, pk(36'h0_0000_0041));
        junk = 6'h15;
        ticks(2);
        chk("junk_15", got, pk(36'h0_0000_0043));

        // Illegal tens preset (12) wraps only when ones carries
        preset({30'd0, 5'd4, 5'd12, 5'd8});
        release_rst();
        ticks(1);
        chk("illegal_tens_hold", got, {30'd0, 5'd4, 5'd12, 5'd9});
        ticks(1);
        chk("illegal_tens_wrap", got, pk(36'h0_0000_0500));

        junk = 6'd0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
